// File: rtl/usb_tx_scheduler_pkg.sv
// Shared types for the USB transmit scheduler: packet command codes,
// scheduler states and the default payload limit.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        PKT_NONE = 2'b00,
        PKT_ACK  = 2'b01,
        PKT_NAK  = 2'b10,
        PKT_DATA = 2'b11
    } tx_packet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_END,
        ST_GAP
    } sched_state_t;

    localparam int MAX_DATA_SIZE_DEF = 64;

endpackage

// File: rtl/usb_tx_sched_counter.sv
// 8-bit saturating counter with synchronous clear, enable and an
// equal-to-target flag; shared by the start timeout and the inter-packet gap.
module usb_tx_sched_counter
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] target,
    output logic       eq
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign eq = (count == target);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake and data requesters onto usb_TX: one-cycle packet
// command, busy-window tracking, start timeout, inter-packet gap, done/err.
module usb_tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int IPG_CYCLES    = 16,
    parameter int START_TIMEOUT = 8,
    parameter int MAX_DATA_SIZE = MAX_DATA_SIZE_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic       hs_nak,
    input  logic       data_req,
    input  logic [6:0] data_size,
    input  logic       tx_busy,
    output logic [1:0] TX_packet,
    output logic [6:0] TX_packet_data_size,
    output logic       hs_done,
    output logic       data_done,
    output logic       tx_err,
    output logic       sched_busy
);

    // The counter is cleared on leaving ISSUE, so it reads k-1 in the k-th
    // cycle after ISSUE; matching START_TIMEOUT-2 lands the pulse START_TIMEOUT
    // cycles after ISSUE.
    localparam logic [7:0] GAP_TGT = 8'(IPG_CYCLES);
    localparam logic [7:0] TO_TGT  = (START_TIMEOUT >= 2) ? 8'(START_TIMEOUT - 2) : 8'd0;
    localparam logic [7:0] MAX_SZ  = 8'(MAX_DATA_SIZE);

    sched_state_t state, state_next;
    tx_packet_t   pkt_q;
    logic [6:0]   size_q;
    logic         owner_hs;

    logic latch, cnt_clr, cnt_en, cnt_eq;
    logic hs_set, data_set, err_set;
    logic oversize;

    assign oversize = ({1'b0, data_size} > MAX_SZ);

    usb_tx_sched_counter u_counter (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .target ((state == ST_GAP) ? GAP_TGT : TO_TGT),
        .eq     (cnt_eq)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            owner_hs  <= 1'b0;
            hs_done   <= 1'b0;
            data_done <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_next;
            hs_done   <= hs_set;
            data_done <= data_set;
            tx_err    <= err_set;
            if (latch) begin
                owner_hs <= hs_req;
            end
        end
    end

    // Payload latches only carry meaning while the owner is active.
    always_ff @(posedge clk) begin
        if (latch) begin
            pkt_q  <= hs_req ? (hs_nak ? PKT_NAK : PKT_ACK) : PKT_DATA;
            size_q <= hs_req ? 7'd0 : data_size;
        end
    end

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        hs_set     = 1'b0;
        data_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs_req || data_req) begin
                    latch = 1'b1;
                    if (!hs_req && oversize) begin
                        data_set   = 1'b1;
                        err_set    = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_clr    = 1'b1;
                state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_END;
                end else if (cnt_eq) begin
                    hs_set     = owner_hs;
                    data_set   = !owner_hs;
                    err_set    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_GAP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (!tx_busy) begin
                    hs_set     = owner_hs;
                    data_set   = !owner_hs;
                    cnt_clr    = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_eq) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign TX_packet  = (state == ST_ISSUE) ? pkt_q : PKT_NONE;
    assign sched_busy = (state != ST_IDLE);
    assign TX_packet_data_size =
        ((state == ST_ISSUE) || (state == ST_WAIT_START) || (state == ST_WAIT_END)) ? size_q : 7'd0;

endmodule

// File: doc/usb_tx_scheduler.md
# usb_tx_scheduler

Sequences the USB transmit datapath by arbitrating between two requesters, the handshake responder (ACK/NAK) and the data-packet source (DATA with a byte count). It sits between the protocol layer and the usb_TX top. It issues one-cycle TX_packet commands, tracks usb_TX's busy window to detect completion, enforces a minimum inter-packet gap, and reports completion or error back to the granted requester.

## Interface
Parameters:
- IPG_CYCLES, 16: idle cycles enforced after busy falls before the next issue; legal range 1..255.
- START_TIMEOUT, 8: cycles after issue within which tx_busy must rise; legal range 1..255.
- MAX_DATA_SIZE, 64: largest legal data payload in bytes.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- hs_req  in  1  handshake request; level, held until hs_done.
- hs_nak  in  1  handshake type: 0 = ACK, 1 = NAK; sampled at grant.
- data_req  in  1  data request; level, held until data_done.
- data_size  in  7  payload bytes (0..127); sampled at grant.
- tx_busy  in  1  busy output of usb_TX.
- TX_packet  out  2  command to usb_TX; non-NONE for exactly one cycle per packet.
- TX_packet_data_size  out  7  latched payload size to usb_TX.
- hs_done  out  1  one-cycle pulse when the handshake transaction ends.
- data_done  out  1  one-cycle pulse when the data transaction ends.
- tx_err  out  1  one-cycle pulse coincident with a done pulse when the transaction failed.
- sched_busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_END, GAP.
- IDLE, arbitration:
  - hs_req has fixed priority over data_req.
  - On grant, latch the owner, the type (ACK, NAK or DATA) and data_size, then go to ISSUE.
  - If nothing is requested, stay in IDLE.
- Oversize reject: if data_req wins and data_size > MAX_DATA_SIZE, do not issue.
  - Pulse data_done and tx_err the next cycle, then go to GAP.
- ISSUE: drive TX_packet with the latched code for exactly one cycle, clear the timeout counter, go to WAIT_START.
- WAIT_START:
  - On tx_busy = 1, go to WAIT_END.
  - Otherwise increment the counter. At START_TIMEOUT, pulse the owner's done and tx_err, then go to GAP.
- WAIT_END: on tx_busy = 0, pulse the owner's done with tx_err = 0, load the gap counter, go to GAP.
- GAP: count IPG_CYCLES cycles, then go to IDLE. Requests are not sampled during GAP.
- Request drop:
  - A request deasserted before grant is never served.
  - A request deasserted after grant does not abort; the done pulse still fires.
- Both requests high at once: handshake served first, data served in the next IDLE after its GAP.
- TX_packet codes: NONE = 00, ACK = 01, NAK = 10, DATA = 11.
- TX_packet_data_size:
  - holds the latched size from ISSUE through WAIT_END;
  - is 0 for handshakes;
  - returns to 0 in GAP.
- data_size = 0 is legal (zero-length DATA packet).
- Counters are 8-bit unsigned, saturating; they are never compared wider than 8 bits.

## Timing
- Reset values: TX_packet = NONE, TX_packet_data_size = 0, all done/err pulses = 0, sched_busy = 0, state = IDLE, counters = 0.
- Reset asserted mid-transaction returns to IDLE immediately; no done pulse is generated.
- Request first sampled high in IDLE at cycle N: ISSUE (TX_packet valid) at N+1.
- Done latency:
  - Normal: the done pulse occurs in the cycle after tx_busy is first sampled low in WAIT_END.
  - Timeout: the done/err pulse occurs START_TIMEOUT cycles after ISSUE.
- Back-to-back issue: the earliest next ISSUE is IPG_CYCLES + 2 cycles after the done pulse.
- If tx_busy is already high in ISSUE, it is ignored; only WAIT_START samples the rise.

## Structure
- Package usb_tx_pkg holds:
  - the tx_packet_t enum (NONE/ACK/NAK/DATA, 2-bit);
  - the scheduler state enum;
  - the MAX_DATA_SIZE default.
- Sub-module usb_tx_sched_counter: an 8-bit clear/enable counter with a compare-equal flag.
  - Instantiated once and shared between the timeout and the gap, which are mutually exclusive states.
- The instantiating level drives usb_TX's TX_packet and TX_packet_data_size directly from this block.

## Test plan
- ACK only: hs_req = 1, hs_nak = 0; tx_busy high 3 cycles after ISSUE for 20 cycles → TX_packet = 01 for 1 cycle, hs_done 1 cycle after busy falls, tx_err = 0.
- Simultaneous: hs_req = 1 (NAK) and data_req = 1, size 8, in the same cycle → NAK issued first; DATA with size 8 issued IPG_CYCLES + 2 cycles after hs_done.
- Timeout: data_req = 1, size 4, tx_busy held 0 → data_done and tx_err pulse 8 cycles after ISSUE; then GAP.
- Oversize: data_size = 65 → no TX_packet activity; data_done + tx_err the cycle after grant.
- Zero-length: data_size = 0 → TX_packet = 11, TX_packet_data_size = 0, normal done.
- Reset mid-WAIT_END: n_rst low for 1 cycle → all outputs 0 asynchronously, no done pulse, new request served normally afterwards.
